// File: rtl/nios2_debug_slave_scan_engine.sv
// Debug data-register scan engine for the Nios II debug slave.
// Runs in the system clock domain from pre-synchronised virtual-JTAG state strobes.
module nios2_debug_slave_scan_engine #(
    parameter int DR_W    = 38,
    parameter int IR_W    = 2,
    parameter int ACT_BIT = 35,
    parameter int CNT_W   = $clog2(DR_W + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tck_en,
    input  logic                       tdi,
    input  logic                       vs_uir,
    input  logic                       vs_cdr,
    input  logic                       vs_sdr,
    input  logic                       vs_udr,
    input  logic [IR_W-1:0]            ir_in,
    input  logic [(2**IR_W)*DR_W-1:0]  cap_data,
    output logic                       tdo,
    output logic [1:0]                 ir_out,
    output logic [IR_W-1:0]            ir_q,
    output logic [DR_W-1:0]            jdo,
    output logic [(2**IR_W)-1:0]       take_action,
    output logic [(2**IR_W)-1:0]       take_no_action,
    output logic                       busy
);

    localparam int N_IR = 2**IR_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DR_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        UPD   = 2'd2
    } state_t;

    state_t              state;
    logic [DR_W-1:0]     sr;
    logic [CNT_W-1:0]    bcnt;
    logic                short_err;
    logic                update_seen;
    logic                in_shift;

    assign in_shift = (state == SHIFT);
    assign tdo      = sr[0];
    assign busy     = in_shift;
    assign ir_out   = {short_err, update_seen};

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sr             <= '0;
            bcnt           <= '0;
            ir_q           <= '0;
            jdo            <= '0;
            short_err      <= 1'b0;
            update_seen    <= 1'b0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            // UPD is a single cycle; a strobe landing in it sees IDLE
            if (state == UPD)
                state <= IDLE;
            if (tck_en) begin
                if (vs_uir) begin
                    ir_q        <= ir_in;
                    update_seen <= 1'b0;
                    short_err   <= 1'b0;
                    state       <= IDLE;
                end else if (vs_udr) begin
                    if (in_shift) begin
                        state <= UPD;
                        if (bcnt == FULL) begin
                            jdo                  <= sr;
                            update_seen          <= 1'b1;
                            take_action[ir_q]    <= sr[ACT_BIT];
                            take_no_action[ir_q] <= ~sr[ACT_BIT];
                        end else begin
                            short_err <= 1'b1;
                        end
                    end
                end else if (vs_cdr) begin
                    sr    <= cap_data[int'(ir_q)*DR_W +: DR_W];
                    bcnt  <= '0;
                    state <= SHIFT;
                end else if (vs_sdr && in_shift) begin
                    sr <= {tdi, sr[DR_W-1:1]};
                    if (bcnt != FULL)
                        bcnt <= bcnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nios2_debug_slave_scan_engine.sv
// Self-checking bench for nios2_debug_slave_scan_engine.
// A bit-queue scan model is compared against the DUT every cycle.
module tb_nios2_debug_slave_scan_engine;

    localparam int DR_W    = 38;
    localparam int IR_W    = 2;
    localparam int ACT_BIT = 35;
    localparam int N_IR    = 4;

    logic                   clk;
    logic                   reset;
    logic                   tck_en;
    logic                   tdi;
    logic                   vs_uir, vs_cdr, vs_sdr, vs_udr;
    logic [IR_W-1:0]        ir_in;
    logic [N_IR*DR_W-1:0]   cap_data;
    logic                   tdo;
    logic [1:0]             ir_out;
    logic [IR_W-1:0]        ir_q;
    logic [DR_W-1:0]        jdo;
    logic [N_IR-1:0]        take_action;
    logic [N_IR-1:0]        take_no_action;
    logic                   busy;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    nios2_debug_slave_scan_engine #(
        .DR_W(DR_W), .IR_W(IR_W), .ACT_BIT(ACT_BIT)
    ) dut (
        .clk(clk), .reset(reset), .tck_en(tck_en), .tdi(tdi),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
        .vs_udr(vs_udr), .ir_in(ir_in), .cap_data(cap_data),
        .tdo(tdo), .ir_out(ir_out), .ir_q(ir_q), .jdo(jdo),
        .take_action(take_action), .take_no_action(take_no_action),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: the scan register is a queue of bits, element 0 is next out
    bit              m_q[$];
    int              m_cnt;
    bit              m_shift;
    logic [IR_W-1:0] m_ir;
    logic [DR_W-1:0] m_jdo;
    bit              m_seen, m_err;
    logic [N_IR-1:0] m_ta, m_tna;

    function automatic logic [DR_W-1:0] pack_q();
        logic [DR_W-1:0] v;
        for (int i = 0; i < DR_W; i++) v[i] = m_q[i];
        return v;
    endfunction

    always @(posedge clk) begin
        m_ta  = '0;
        m_tna = '0;
        if (reset) begin
            m_q.delete();
            for (int i = 0; i < DR_W; i++) m_q.push_back(1'b0);
            m_cnt = 0; m_shift = 0; m_ir = '0; m_jdo = '0;
            m_seen = 0; m_err = 0;
        end else if (tck_en) begin
            if (vs_uir) begin
                m_ir = ir_in; m_seen = 0; m_err = 0; m_shift = 0;
            end else if (vs_udr) begin
                if (m_shift) begin
                    m_shift = 0;
                    if (m_cnt >= DR_W) begin
                        m_jdo = pack_q();
                        m_seen = 1;
                        if (m_jdo[ACT_BIT]) m_ta[m_ir] = 1'b1;
                        else                m_tna[m_ir] = 1'b1;
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (vs_cdr) begin
                m_q.delete();
                for (int i = 0; i < DR_W; i++)
                    m_q.push_back(cap_data[int'(m_ir)*DR_W + i]);
                m_cnt = 0; m_shift = 1;
            end else if (vs_sdr && m_shift) begin
                void'(m_q.pop_front());
                m_q.push_back(tdi);
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("tdo", 64'(tdo), 64'(m_q[0]));
            check("ir_out", 64'(ir_out), 64'({m_err, m_seen}));
            check("ir_q", 64'(ir_q), 64'(m_ir));
            check("jdo", 64'(jdo), 64'(m_jdo));
            check("take_action", 64'(take_action), 64'(m_ta));
            check("take_no_action", 64'(take_no_action), 64'(m_tna));
            check("busy", 64'(busy), 64'(m_shift));
        end
    end

    task automatic tick(input bit en, input bit u, input bit c,
                        input bit s, input bit d, input bit t,
                        input logic [IR_W-1:0] ir);
        tck_en = en; vs_uir = u; vs_cdr = c; vs_sdr = s;
        vs_udr = d; tdi = t; ir_in = ir;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Gap cycles keep vs_sdr high with tck_en low to exercise gating
    task automatic shift_bits(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            tick(1, 0, 0, 1, 0, bits[i], 0);
            tick(0, 0, 0, 1, 0, ~bits[i], 0);
        end
    endtask

    logic [DR_W-1:0] cap2, word, got, jdo_before;

    initial begin
        cap2 = 38'h2A_5A5A_5A5A;
        cap_data = {38'h15_0F0F_0F0F, cap2, 38'h03_1234_5678, 38'h00_ABCD_EF01};
        reset = 1'b1;
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        started = 1;
        check("rst_jdo", 64'(jdo), 64'h0);
        check("rst_ir_out", 64'(ir_out), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        idle(2);

        // Full scan, action path
        tick(1, 1, 0, 0, 0, 0, 2'd2);
        idle(1);
        tick(1, 0, 1, 0, 0, 0, 0);
        check("busy_after_cdr", 64'(busy), 64'h1);
        word = 38'h08_0000_1234;
        for (int i = 0; i < DR_W; i++) begin
            got[i] = tdo;
            tick(1, 0, 0, 1, 0, word[i], 0);
            idle(1);
        end
        check("tdo_serial", 64'(got), 64'h2A_5A5A_5A5A);
        tick(1, 0, 0, 0, 1, 0, 0);
        check("full_jdo", 64'(jdo), 64'h08_0000_1234);
        check("full_ta", 64'(take_action), 64'h4);
        check("full_ir_out", 64'(ir_out), 64'h1);
        idle(1);
        check("full_ta_drop", 64'(take_action), 64'h0);

        // No-action path
        tick(1, 1, 0, 0, 0, 0, 2'd2);
        tick(1, 0, 1, 0, 0, 0, 0);
        shift_bits(64'hFF, DR_W);
        tick(1, 0, 0, 0, 1, 0, 0);
        check("noact_tna", 64'(take_no_action), 64'h4);
        check("noact_ta", 64'(take_action), 64'h0);
        idle(2);

        // Short scan
        jdo_before = jdo;
        tick(1, 1, 0, 0, 0, 0, 2'd2);
        tick(1, 0, 1, 0, 0, 0, 0);
        shift_bits(64'h3F_FFFF_FFFF, DR_W - 1);
        tick(1, 0, 0, 0, 1, 0, 0);
        check("short_ta", 64'(take_action | take_no_action), 64'h0);
        check("short_jdo", 64'(jdo), 64'(jdo_before));
        check("short_ir_out", 64'(ir_out), 64'h2);
        idle(1);
        tick(1, 1, 0, 0, 0, 0, 2'd1);
        check("uir_clear", 64'(ir_out), 64'h0);

        // Over-length scan on instruction 1
        tick(1, 0, 1, 0, 0, 0, 0);
        word = 38'h3F_0000_ABCD;
        shift_bits({24'h0, word, 2'b11}, DR_W + 2);
        tick(1, 0, 0, 0, 1, 0, 0);
        check("over_jdo", 64'(jdo), 64'h3F_0000_ABCD);
        check("over_ta", 64'(take_action), 64'h2);
        // cdr landing in the UPD cycle re-enters SHIFT
        tick(1, 0, 1, 0, 0, 0, 0);
        check("upd_cdr_busy", 64'(busy), 64'h1);

        // uir and udr together after a full-length shift
        shift_bits(64'h3F_FFFF_FFFF, DR_W);
        tick(1, 1, 0, 0, 1, 0, 2'd3);
        check("uir_udr_ir", 64'(ir_q), 64'h3);
        check("uir_udr_pulse", 64'(take_action | take_no_action), 64'h0);
        idle(1);

        // udr in IDLE
        tick(1, 0, 0, 0, 1, 0, 0);
        check("idle_udr", 64'(take_action | take_no_action), 64'h0);
        idle(1);

        // Reset mid-shift at bcnt = 10
        tick(1, 0, 1, 0, 0, 0, 0);
        shift_bits(64'h2AA, 10);
        reset = 1'b1;
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        check("rst2_busy", 64'(busy), 64'h0);
        check("rst2_ir_q", 64'(ir_q), 64'h0);
        check("rst2_jdo", 64'(jdo), 64'h0);
        check("rst2_tdo", 64'(tdo), 64'h0);
        tick(1, 0, 0, 0, 1, 0, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios2_debug_slave_scan_engine.md
# nios2_debug_slave_scan_engine

Parametrised, single-clock successor to the Nios II debug-slave TCK/sysclk pair. It performs the debug data-register scan in the system clock domain from pre-synchronised virtual-JTAG state strobes. It latches the instruction, captures per-instruction readback data, shifts `DR_W` bits, and on update emits one-cycle take_action / take_no_action pulses per instruction. It sits between the virtual-JTAG synchroniser and the OCI break/ocimem/trace control logic, replacing the fixed 38-bit, 2-bit-IR decode with a generic one that also detects short scans.

## Interface
Parameters:
- `DR_W`, 38: data-register width; legal range 8 to 64.
- `IR_W`, 2: instruction width; `N_IR = 2**IR_W` instructions.
- `ACT_BIT`, 35: bit of the shifted-in word that selects take_action (1) or take_no_action (0); must be less than `DR_W`.
- `CNT_W`, `$clog2(DR_W+1)`: width of the bit counter (derived; do not override).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `tck_en`  in  1  one-cycle strobe marking a synchronised TCK rising edge; all state strobes below are qualified by it.
- `tdi`  in  1  serial data in, valid with `tck_en`.
- `vs_uir`, `vs_cdr`, `vs_sdr`, `vs_udr`  in  1 each  virtual update-IR, capture-DR, shift-DR and update-DR states.
- `ir_in`  in  `IR_W`  instruction, valid with `vs_uir`.
- `cap_data`  in  `N_IR*DR_W`  capture word per instruction; slice `k` is `[k*DR_W +: DR_W]`.
- `tdo`  out  1  serial data out; always equals `sr[0]`.
- `ir_out`  out  2  `{short_err, update_seen}` status word.
- `ir_q`  out  `IR_W`  latched instruction.
- `jdo`  out  `DR_W`  last completed update word.
- `take_action`  out  `N_IR`  one-hot, one-cycle pulse.
- `take_no_action`  out  `N_IR`  one-hot, one-cycle pulse.
- `busy`  out  1  high while in SHIFT.

## Operation
- Internal state: shift register `sr[DR_W-1:0]`, counter `bcnt[CNT_W-1:0]`, FSM with states IDLE, SHIFT and UPD.
- Strobe events are recognised only in cycles where `tck_en` is 1; in all other cycles the FSM, `sr` and `bcnt` hold.
- If several `vs_*` strobes are high together, priority is uir > udr > cdr > sdr. Exactly one event is taken; the others are dropped.
- **uir:** `ir_q <= ir_in`; `update_seen` and `short_err` clear; FSM goes to IDLE.
- **cdr:** `sr <= cap_data` slice for `ir_q`; `bcnt <= 0`; FSM goes to SHIFT. Taken from any state.
- **sdr, in SHIFT:** `sr <= {tdi, sr[DR_W-1:1]}`; `bcnt` increments and saturates at `DR_W`. Over-length scans are legal: the last `DR_W` bits are kept.
- **sdr, outside SHIFT:** ignored.
- **udr, in SHIFT:** FSM goes to UPD.
  - If `bcnt == DR_W`: `jdo <= sr`, `update_seen <= 1`.
  - Otherwise: `short_err <= 1`; `jdo` holds and no pulse is generated.
- **udr, outside SHIFT:** ignored; no pulse.
- **UPD:** lasts exactly one cycle regardless of `tck_en`.
  - If the update was full-length, drive `take_action[ir_q] = jdo[ACT_BIT]` and `take_no_action[ir_q] = ~jdo[ACT_BIT]`.
  - Then return to IDLE.
- The pulse vectors are zero in every cycle other than UPD. At most one bit across both vectors is ever set.
- `busy` is high exactly when the FSM is in SHIFT.

## Timing
- Reset values: FSM in IDLE, `sr = 0`, `bcnt = 0`, `ir_q = 0`, `jdo = 0`, `ir_out = 2'b00`, `tdo = 0`, both pulse vectors 0, `busy = 0`.
- Reset takes effect on the same edge it is sampled. A reset during SHIFT or UPD aborts with no pulse.
- Latency:
  - udr strobe in cycle n: `jdo` updates at edge n+1; the pulse is high in cycle n+1 only.
  - cdr strobe in cycle n: `tdo` shows capture bit 0 from cycle n+1.
  - sdr strobe in cycle n: `tdo` shows the next bit from cycle n+1.
- All outputs are registered; there is no combinational path from any input to any output.
- A `tck_en` arriving in the UPD cycle is still evaluated, with IDLE as the current state. So cdr re-enters SHIFT, and udr or sdr is ignored.
- `jdo` is stable between full-length updates. Downstream logic samples it alongside the pulse.

## Test plan
- **Reset:** hold `reset` 3 cycles mid-shift (`bcnt = 10`) -> all outputs return to reset values; no pulse at any time.
- **Full scan:** `DR_W=38`, `IR_W=2`; uir with `ir_in=2`; cdr with `cap_data` slice 2 = `38'h2A_5A5A_5A5A`; 38 sdr shifting in `38'h08_0000_1234` (bit 35 = 1); udr.
  - `tdo` serializes `0x2A5A5A5A5A` LSB first.
  - `jdo = 0x0800001234` one cycle after udr.
  - `take_action = 4'b0100` for one cycle; `ir_out = 2'b01`.
- **No-action path:** same as the full scan but shifting in `38'h00_0000_00FF` -> `take_no_action = 4'b0100` for one cycle; `take_action` stays 0.
- **Short scan:** 37 sdr then udr -> no pulse; `jdo` unchanged; `ir_out = 2'b10`.
  - A following uir clears `ir_out` to `2'b00`.
- **Over-length scan:** 40 sdr with 2 dummy leading bits, then udr -> `jdo` equals the last 38 bits shifted in; pulse generated.
- **Simultaneous strobes and gating:**
  - uir and udr high on the same strobe -> IR latched and no pulse.
  - sdr high while `tck_en = 0` -> `sr` unchanged.
  - udr received in IDLE -> no pulse.
